// File: rtl/core2mem_pkg.sv
// Shared types and width helpers for the CPU-to-memory width bridge.
package core2mem_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  localparam int WDOG_W = 16;

  function automatic int lane_count(input int cpu_w, input int mem_w);
    return mem_w / cpu_w;
  endfunction

  // Lane index is kept at least one bit wide so a single-lane build still has a legal vector.
  function automatic int lane_idx_width(input int cpu_w, input int mem_w);
    return (mem_w / cpu_w > 1) ? $clog2(mem_w / cpu_w) : 1;
  endfunction

  function automatic int lane_lsb(input int cpu_w);
    return $clog2(cpu_w / 8);
  endfunction

endpackage

// File: rtl/core2mem_lane_sel.sv
// Picks the CPU-sized lane out of a memory beat and places the CPU byte mask in that lane.
module core2mem_lane_sel
  import core2mem_pkg::*;
#(
  parameter int CPU_WIDTH = 64,
  parameter int MEM_WIDTH = 128,
  parameter int LANE_W    = lane_idx_width(CPU_WIDTH, MEM_WIDTH)
) (
  input  logic [LANE_W-1:0]      lane_idx,
  input  logic [MEM_WIDTH-1:0]   mem_rdata,
  input  logic [CPU_WIDTH-1:0]   wdata,
  input  logic [CPU_WIDTH/8-1:0] wmask,
  output logic [CPU_WIDTH-1:0]   rdata_lane,
  output logic [MEM_WIDTH-1:0]   mem_wdata,
  output logic [MEM_WIDTH/8-1:0] mem_wmask
);

  localparam int LANES = lane_count(CPU_WIDTH, MEM_WIDTH);
  localparam int CPU_BYTES = CPU_WIDTH / 8;

  assign mem_wdata = {LANES{wdata}};

  always_comb begin
    rdata_lane = '0;
    mem_wmask  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == LANE_W'(i)) begin
        rdata_lane = mem_rdata[i*CPU_WIDTH +: CPU_WIDTH];
        mem_wmask[i*CPU_BYTES +: CPU_BYTES] = wmask;
      end
    end
  end

endmodule

// File: rtl/core2mem_bridge.sv
// Bridges a narrow CPU load/store port onto a wide memory beat interface.
// Define CORE2MEM_TIMEOUT_EN to add a watchdog that aborts stuck accesses with mem_err.
module core2mem_bridge
  import core2mem_pkg::*;
#(
  parameter int CPU_WIDTH  = 64,
  parameter int MEM_WIDTH  = 128,
  parameter int ADDR_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   address_cpu,
  input  logic                    ren_cpu,
  input  logic                    wen_cpu,
  input  logic [CPU_WIDTH-1:0]    wdata_cpu,
  input  logic [CPU_WIDTH/8-1:0]  wmask_cpu,
  output logic [CPU_WIDTH-1:0]    rdata_cpu,
  output logic                    mem_stall,
  output logic                    mem_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [MEM_WIDTH-1:0]    mem_wdata,
  output logic [MEM_WIDTH/8-1:0]  mem_wmask,
  input  logic [MEM_WIDTH-1:0]    mem_rdata,
  input  logic                    mem_rvalid,
  input  logic                    mem_wvalid
);

  localparam int LANES  = lane_count(CPU_WIDTH, MEM_WIDTH);
  localparam int LANE_W = lane_idx_width(CPU_WIDTH, MEM_WIDTH);
  localparam int OFF    = lane_lsb(CPU_WIDTH);

  if (CPU_WIDTH < 8 || MEM_WIDTH < CPU_WIDTH || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("core2mem_bridge: illegal parameter combination");
  end

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CPU_WIDTH-1:0]   wdata_q;
  logic [CPU_WIDTH/8-1:0] wmask_q;
  logic [LANE_W-1:0]      lane_q;
  logic [LANE_W-1:0]      lane_in;
  logic [CPU_WIDTH-1:0]   rdata_lane;
  logic                   timeout_hit;

  if (LANES > 1) begin : g_lane
    assign lane_in = address_cpu[OFF +: LANE_W];
  end else begin : g_single
    assign lane_in = '0;
  end

  core2mem_lane_sel #(
    .CPU_WIDTH (CPU_WIDTH),
    .MEM_WIDTH (MEM_WIDTH),
    .LANE_W    (LANE_W)
  ) u_lane_sel (
    .lane_idx   (lane_q),
    .mem_rdata  (mem_rdata),
    .wdata      (wdata_q),
    .wmask      (wmask_q),
    .rdata_lane (rdata_lane),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask)
  );

`ifdef CORE2MEM_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
  logic              in_wait;
  logic              strobe_match;

  assign in_wait      = (state == RD_WAIT) || (state == WR_WAIT);
  assign strobe_match = ((state == RD_WAIT) && mem_rvalid) || ((state == WR_WAIT) && mem_wvalid);
  assign timeout_hit  = in_wait && (wdog_q == WDOG_W'(TIMEOUT - 1));
  assign mem_err      = err_q;

  // Counter is zero on the first WAIT cycle, so TIMEOUT waiting cycles elapse before the abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= timeout_hit && !strobe_match;
      wdog_q <= in_wait ? wdog_q + 1'b1 : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (wen_cpu) state_nx = WR_WAIT;
        else if (ren_cpu) state_nx = RD_WAIT;
      end
      RD_WAIT: if (mem_rvalid || timeout_hit) state_nx = RESP;
      WR_WAIT: if (mem_wvalid || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      lane_q    <= '0;
      rdata_cpu <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (ren_cpu || wen_cpu)) begin
        addr_q  <= address_cpu;
        wdata_q <= wdata_cpu;
        wmask_q <= wmask_cpu;
        lane_q  <= lane_in;
      end
      if (state == RD_WAIT) begin
        if (mem_rvalid) rdata_cpu <= rdata_lane;
        else if (timeout_hit) rdata_cpu <= '0;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_ren   = (state == RD_WAIT);
  assign mem_wen   = (state == WR_WAIT);
  assign mem_stall = ((state == IDLE) && (ren_cpu || wen_cpu)) || mem_ren || mem_wen;

endmodule

// File: tb/tb_core2mem_bridge.sv
// Scoreboard bench for core2mem_bridge: directed accesses push expected memory requests
// and CPU responses; independent monitors pop and compare as the bridge presents them.
module tb_core2mem_bridge;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  address_cpu = '0;
  logic         ren_cpu = 1'b0, wen_cpu = 1'b0;
  logic [63:0]  wdata_cpu = '0;
  logic [7:0]   wmask_cpu = '0;
  logic [63:0]  rdata_cpu;
  logic         mem_stall, mem_err, mem_ren, mem_wen;
  logic [63:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wmask;
  logic [127:0] mem_rdata = '0;
  logic         mem_rvalid = 1'b0, mem_wvalid = 1'b0;

  logic [63:0]  address_cpu1 = '0;
  logic         ren_cpu1 = 1'b0, wen_cpu1 = 1'b0;
  logic [63:0]  wdata_cpu1 = '0;
  logic [7:0]   wmask_cpu1 = '0;
  logic [63:0]  rdata_cpu1;
  logic         mem_stall1, mem_err1, mem_ren1, mem_wen1;
  logic [63:0]  mem_addr1;
  logic [63:0]  mem_wdata1;
  logic [7:0]   mem_wmask1;
  logic [63:0]  mem_rdata1 = '0;
  logic         mem_rvalid1 = 1'b0, mem_wvalid1 = 1'b0;

  core2mem_bridge #(.CPU_WIDTH(64), .MEM_WIDTH(128), .ADDR_WIDTH(64), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rstn(rstn), .address_cpu(address_cpu), .ren_cpu(ren_cpu), .wen_cpu(wen_cpu),
    .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu), .rdata_cpu(rdata_cpu), .mem_stall(mem_stall),
    .mem_err(mem_err), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid)
  );

  core2mem_bridge #(.CPU_WIDTH(64), .MEM_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rstn(rstn), .address_cpu(address_cpu1), .ren_cpu(ren_cpu1), .wen_cpu(wen_cpu1),
    .wdata_cpu(wdata_cpu1), .wmask_cpu(wmask_cpu1), .rdata_cpu(rdata_cpu1), .mem_stall(mem_stall1),
    .mem_err(mem_err1), .mem_addr(mem_addr1), .mem_ren(mem_ren1), .mem_wen(mem_wen1),
    .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1), .mem_rdata(mem_rdata1),
    .mem_rvalid(mem_rvalid1), .mem_wvalid(mem_wvalid1)
  );

  typedef struct {
    bit           wr;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
  } req_t;

  typedef struct {
    logic [63:0] rdata;
    bit          err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int failures = 0;
  logic [63:0] last_rd = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: a stall falling out of busy marks the RESP cycle.
  bit   prev_stall = 1'b0;
  rsp_t mon_rsp;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !mem_stall) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp actual=rdata %h required=no response", rdata_cpu);
        end else begin
          mon_rsp = rsp_q.pop_front();
          checkOutput("rsp_rdata", rdata_cpu, mon_rsp.rdata);
          checkOutput("rsp_err", mem_err, mon_rsp.err);
        end
      end
      prev_stall = mem_stall;
    end
  end

  // Request monitor: first strobe cycle pops an expectation, later cycles check stability.
  bit   in_req = 1'b0;
  req_t cur;
  always @(negedge clk) begin
    if (!rstn) begin
      in_req = 1'b0;
    end else if (mem_ren || mem_wen) begin
      if (!in_req) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_req actual=ren %b wen %b required=idle", mem_ren, mem_wen);
        end else begin
          cur = req_q.pop_front();
          in_req = 1'b1;
        end
      end
      if (in_req) begin
        checkOutput("req_ren", mem_ren, !cur.wr);
        checkOutput("req_wen", mem_wen, cur.wr);
        checkOutput("req_addr", mem_addr, cur.addr);
        if (cur.wr) begin
          checkOutput("req_wdata", mem_wdata, cur.wdata);
          checkOutput("req_wmask", mem_wmask, cur.wmask);
        end
      end
    end else begin
      in_req = 1'b0;
    end
  end

  // One access: request in cycle 0, strobe in cycle k (if strobe), RESP expected in cycle k+1.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wmask,
                               input logic [127:0] beat, input int k, input bit strobe,
                               input bit stray, input logic [63:0] exp_rd,
                               input logic [15:0] exp_mask, input bit exp_err);
    req_t r;
    rsp_t s;
    @(posedge clk); #1;
    ren_cpu = rd;
    wen_cpu = wr;
    address_cpu = addr;
    wdata_cpu = wdata;
    wmask_cpu = wmask;
    r.wr = wr;
    r.addr = addr;
    r.wdata = {2{wdata}};
    r.wmask = exp_mask;
    req_q.push_back(r);
    if (!wr) last_rd = exp_rd;
    s.rdata = last_rd;
    s.err = exp_err;
    rsp_q.push_back(s);
    for (int c = 0; c <= k; c++) begin
      mem_rvalid = 1'b0;
      mem_wvalid = 1'b0;
      if (strobe && c == k) begin
        if (wr) mem_wvalid = 1'b1;
        else begin
          mem_rvalid = 1'b1;
          mem_rdata = beat;
        end
      end else if (stray && c >= 1) begin
        if (wr) mem_rvalid = 1'b1;
        else mem_wvalid = 1'b1;
        mem_rdata = ~beat;
      end
      @(negedge clk);
      checkOutput("stall_busy", mem_stall, 1'b1);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_wvalid = 1'b0;
    ren_cpu = 1'b0;
    wen_cpu = 1'b0;
    @(negedge clk);
    checkOutput("stall_resp", mem_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    req_t r;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rdata", rdata_cpu, 64'd0);
    checkOutput("reset_stall", mem_stall, 1'b0);
    checkOutput("reset_ren", mem_ren, 1'b0);
    checkOutput("reset_wen", mem_wen, 1'b0);
    checkOutput("reset_err", mem_err, 1'b0);
    checkOutput("reset_addr", mem_addr, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Upper lane read, strobe in cycle 2.
    applyStimulus(1'b0, 1'b1, 64'h1008, 64'h0, 8'h00,
                  {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 2, 1'b1, 1'b0,
                  64'hAAAA_AAAA_AAAA_AAAA, 16'h0000, 1'b0);
    // Lower lane write.
    applyStimulus(1'b1, 1'b0, 64'h1000, 64'h1234, 8'h0F, '0, 1, 1'b1, 1'b0,
                  64'h0, 16'h000F, 1'b0);
    // Read and write together: write wins, stray rvalid ignored in WR_WAIT.
    applyStimulus(1'b1, 1'b1, 64'h1018, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, '0, 2, 1'b1, 1'b1,
                  64'h0, 16'hF000, 1'b0);
    // Lower lane read with stray wvalid during RD_WAIT.
    applyStimulus(1'b0, 1'b1, 64'h2000, 64'h0, 8'h00,
                  {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 3, 1'b1, 1'b1,
                  64'h2222_2222_2222_2222, 16'h0000, 1'b0);
    // Back-to-back accesses, no bubble after RESP.
    applyStimulus(1'b0, 1'b1, 64'h3008, 64'h0, 8'h00,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 1, 1'b1, 1'b0,
                  64'h0123_4567_89AB_CDEF, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 64'h3000, 64'h0, 8'h00,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 1, 1'b1, 1'b0,
                  64'hFEDC_BA98_7654_3210, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h3008, 64'h55AA, 8'h81, '0, 1, 1'b1, 1'b0,
                  64'h0, 16'h8100, 1'b0);

    // Strobes while idle must not start or capture anything.
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_wvalid = 1'b1;
    mem_rdata = {2{64'h7777_7777_7777_7777}};
    @(negedge clk);
    checkOutput("idle_strobe_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_wvalid = 1'b0;
    @(negedge clk);
    checkOutput("idle_strobe_rdata", rdata_cpu, 64'hFEDC_BA98_7654_3210);
    checkOutput("idle_strobe_ren", mem_ren, 1'b0);

    // Reset while a read is waiting, then a late strobe.
    @(posedge clk); #1;
    ren_cpu = 1'b1;
    address_cpu = 64'h2010;
    r.wr = 1'b0;
    r.addr = 64'h2010;
    r.wdata = '0;
    r.wmask = '0;
    req_q.push_back(r);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    ren_cpu = 1'b0;
    #1;
    checkOutput("rst_mid_ren", mem_ren, 1'b0);
    checkOutput("rst_mid_wen", mem_wen, 1'b0);
    checkOutput("rst_mid_stall", mem_stall, 1'b0);
    checkOutput("rst_mid_rdata", rdata_cpu, 64'd0);
    checkOutput("rst_mid_err", mem_err, 1'b0);
    checkOutput("rst_mid_addr", mem_addr, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = {2{64'h9999_9999_9999_9999}};
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late_strobe_rdata", rdata_cpu, 64'd0);
    checkOutput("late_strobe_stall", mem_stall, 1'b0);
    checkOutput("late_strobe_ren", mem_ren, 1'b0);
    last_rd = '0;

    // Normal access after reset.
    applyStimulus(1'b0, 1'b1, 64'h4008, 64'h0, 8'h00,
                  {64'hCAFE_CAFE_CAFE_CAFE, 64'hBEEF_BEEF_BEEF_BEEF}, 1, 1'b1, 1'b0,
                  64'hCAFE_CAFE_CAFE_CAFE, 16'h0000, 1'b0);

`ifdef CORE2MEM_TIMEOUT_EN
    // No strobe: abort after TO waiting cycles with an error pulse and zeroed read data.
    applyStimulus(1'b0, 1'b1, 64'h5000, 64'h0, 8'h00, '0, TO, 1'b0, 1'b0,
                  64'h0, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("err_pulse_end", mem_err, 1'b0);
`endif

    // Single-lane build returns the whole beat and passes the mask straight through.
    @(posedge clk); #1;
    ren_cpu1 = 1'b1;
    address_cpu1 = 64'h40;
    @(negedge clk);
    checkOutput("l1_stall_c0", mem_stall1, 1'b1);
    @(posedge clk); #1;
    mem_rvalid1 = 1'b1;
    mem_rdata1 = 64'h0F1E_2D3C_4B5A_6978;
    @(negedge clk);
    checkOutput("l1_ren", mem_ren1, 1'b1);
    @(posedge clk); #1;
    mem_rvalid1 = 1'b0;
    ren_cpu1 = 1'b0;
    @(negedge clk);
    checkOutput("l1_rdata", rdata_cpu1, 64'h0F1E_2D3C_4B5A_6978);
    checkOutput("l1_stall_resp", mem_stall1, 1'b0);
    @(posedge clk); #1;
    wen_cpu1 = 1'b1;
    address_cpu1 = 64'h48;
    wdata_cpu1 = 64'h0000_0000_ABCD_0123;
    wmask_cpu1 = 8'h3C;
    @(posedge clk); #1;
    mem_wvalid1 = 1'b1;
    @(negedge clk);
    checkOutput("l1_wmask", mem_wmask1, 8'h3C);
    checkOutput("l1_wdata", mem_wdata1, 64'h0000_0000_ABCD_0123);
    checkOutput("l1_addr", mem_addr1, 64'h48);
    @(posedge clk); #1;
    mem_wvalid1 = 1'b0;
    wen_cpu1 = 1'b0;
    @(negedge clk);
    checkOutput("l1_wr_rdata_hold", rdata_cpu1, 64'h0F1E_2D3C_4B5A_6978);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("req_q_drained", req_q.size(), 0);
    checkOutput("rsp_q_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
